// File: rtl/osd_regaccess_wide.sv
// OSD register-access endpoint for 16..128-bit accesses; local base regs 0x000-0x1ff, others on reg_*.
// Optional OSD_REGACCESS_TIMEOUT_EN bounds external accesses to TIMEOUT_CYCLES; responses hold under backpressure.
package osd_regaccess_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module osd_regaccess_wide
  import osd_regaccess_pkg::*;
#(
  parameter logic [15:0] MOD_VENDOR     = 16'h0000,
  parameter logic [15:0] MOD_TYPE       = 16'h0000,
  parameter logic [15:0] MOD_VERSION    = 16'h0000,
  parameter logic [15:0] MOD_EVENT_DEST = 16'h0000,
  parameter bit          CAN_STALL      = 1'b0,
  parameter int          MAX_REG_SIZE   = 64,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             id,
  input  dii_flit                 debug_in,
  output logic                    debug_in_ready,
  output dii_flit                 debug_out,
  input  logic                    debug_out_ready,
  output logic                    reg_request,
  output logic                    reg_write,
  output logic [15:0]             reg_addr,
  output logic [1:0]              reg_size,
  output logic [MAX_REG_SIZE-1:0] reg_wdata,
  input  logic                    reg_ack,
  input  logic                    reg_err,
  input  logic [MAX_REG_SIZE-1:0] reg_rdata,
  output logic                    stall
);

  localparam int W = MAX_REG_SIZE;

  if (!(W == 16 || W == 32 || W == 64 || W == 128) || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("osd_regaccess_wide: unsupported MAX_REG_SIZE or TIMEOUT_CYCLES");
  end

  typedef enum logic [3:0] {
    IDLE, HDR_SRC, HDR_TYPE, ADDR, WDATA, EXT_REQ,
    RESP_DEST, RESP_SRC, RESP_HDR, RESP_DATA, DROP
  } state_t;

  state_t      state, state_n;
  logic [15:0] src, addr, cur_addr, local_val;
  logic        wr, err, err_n, stall_bit;
  logic [1:0]  size;
  logic [2:0]  cnt, nlast;
  logic [W-1:0] wbuf, rbuf;
  logic        in_fire, size_bad, cur_local, local_rd_ok, local_wr_ok;
  logic        ld_local, ld_ext, stall_we, cnt_clr, cnt_inc;

  assign debug_in_ready = !rst && (state == IDLE || state == HDR_SRC || state == HDR_TYPE ||
                                   state == ADDR || state == WDATA || state == DROP);
  assign in_fire = debug_in.valid && debug_in_ready;

  // The address is still on the input bus while in ADDR; later it comes from the register.
  assign cur_addr    = (state == ADDR) ? debug_in.data : addr;
  assign cur_local   = (cur_addr[15:9] == 7'd0);
  assign nlast       = 3'((4'd1 << size) - 4'd1);
  assign size_bad    = (16 << size) > W;
  assign local_rd_ok = (size == 2'd0) && (cur_addr <= 16'd4);
  assign local_wr_ok = CAN_STALL && (size == 2'd0) && (cur_addr == 16'd3) &&
                       (debug_in.data[15:11] == 5'h1);

  always_comb begin
    local_val = 16'h0000;
    case (cur_addr)
      16'd0:   local_val = MOD_VENDOR;
      16'd1:   local_val = MOD_TYPE;
      16'd2:   local_val = MOD_VERSION;
      16'd3:   local_val = {5'h1, 10'h000, stall_bit};
      16'd4:   local_val = MOD_EVENT_DEST;
      default: local_val = 16'h0000;
    endcase
  end

`ifdef OSD_REGACCESS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != EXT_REQ) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    err_n    = err;
    ld_local = 1'b0;
    ld_ext   = 1'b0;
    stall_we = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE:     if (in_fire && !debug_in.last) state_n = HDR_SRC;
      HDR_SRC:  if (in_fire) state_n = debug_in.last ? IDLE : HDR_TYPE;
      HDR_TYPE: if (in_fire) begin
        err_n = 1'b0;
        if (debug_in.last)                     state_n = IDLE;
        else if (debug_in.data[15:14] != 2'b00) state_n = DROP;
        else                                   state_n = ADDR;
      end
      ADDR: if (in_fire) begin
        cnt_clr = 1'b1;
        if (wr) begin
          if (debug_in.last) begin err_n = 1'b1; state_n = RESP_DEST; end
          else state_n = WDATA;
        end else if (!debug_in.last) begin
          err_n = 1'b1; state_n = DROP;
        end else if (size_bad) begin
          err_n = 1'b1; state_n = RESP_DEST;
        end else if (cur_local) begin
          err_n = !local_rd_ok; ld_local = 1'b1; state_n = RESP_DEST;
        end else begin
          state_n = EXT_REQ;
        end
      end
      WDATA: if (in_fire) begin
        cnt_inc = 1'b1;
        if (cnt == nlast) begin
          if (!debug_in.last) begin
            err_n = 1'b1; state_n = DROP;
          end else if (size_bad) begin
            err_n = 1'b1; state_n = RESP_DEST;
          end else if (cur_local) begin
            err_n = !local_wr_ok; stall_we = local_wr_ok; state_n = RESP_DEST;
          end else begin
            state_n = EXT_REQ;
          end
        end else if (debug_in.last) begin
          err_n = 1'b1; state_n = RESP_DEST;
        end
      end
      EXT_REQ: begin
        if (reg_ack || reg_err) begin
          err_n = reg_err; ld_ext = !reg_err; state_n = RESP_DEST;
        end
`ifdef OSD_REGACCESS_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_n = 1'b1; state_n = RESP_DEST;
        end
`endif
      end
      RESP_DEST: if (debug_out_ready) state_n = RESP_SRC;
      RESP_SRC:  if (debug_out_ready) state_n = RESP_HDR;
      RESP_HDR:  if (debug_out_ready) begin
        cnt_clr = 1'b1;
        state_n = (wr || err) ? IDLE : RESP_DATA;
      end
      RESP_DATA: if (debug_out_ready) begin
        cnt_inc = 1'b1;
        if (cnt == nlast) state_n = IDLE;
      end
      DROP: if (in_fire && debug_in.last) state_n = err ? RESP_DEST : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    debug_out = '0;
    case (state)
      RESP_DEST: debug_out = '{valid: 1'b1, last: 1'b0, data: src};
      RESP_SRC:  debug_out = '{valid: 1'b1, last: 1'b0, data: id};
      RESP_HDR: begin
        debug_out.valid = 1'b1;
        debug_out.last  = wr || err;
        if (wr)       debug_out.data = {2'b00, 3'b111, err, 10'h000};
        else if (err) debug_out.data = {2'b00, 4'b1100, 10'h000};
        else          debug_out.data = {2'b00, 2'b10, size, 10'h000};
      end
      RESP_DATA: debug_out = '{valid: 1'b1, last: (cnt == nlast), data: rbuf[W-1 -: 16]};
      default:   debug_out = '0;
    endcase
  end

  // Read data is left-justified in rbuf so the MS word of any size is always at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      cnt       <= 3'd0;
      stall_bit <= 1'b1;
      src       <= 16'h0000;
      addr      <= 16'h0000;
      wr        <= 1'b0;
      size      <= 2'd0;
      wbuf      <= '0;
      rbuf      <= '0;
    end else begin
      err <= err_n;
      if (cnt_clr)      cnt <= 3'd0;
      else if (cnt_inc) cnt <= cnt + 3'd1;
      if (state == HDR_SRC && in_fire) src <= debug_in.data;
      if (state == HDR_TYPE && in_fire) begin
        wr   <= debug_in.data[12];
        size <= debug_in.data[11:10];
      end
      if (state == ADDR && in_fire) begin
        addr <= debug_in.data;
        wbuf <= '0;
      end
      if (state == WDATA && in_fire) wbuf <= W'({wbuf, debug_in.data});
      if (stall_we) stall_bit <= debug_in.data[0];
      if (ld_local)    rbuf <= W'(local_val) << (W - 16);
      else if (ld_ext) rbuf <= reg_rdata << (W - (16 << size));
      else if (state == RESP_DATA && debug_out_ready) rbuf <= rbuf << 16;
    end
  end

  assign reg_request = (state == EXT_REQ);
  assign reg_write   = wr;
  assign reg_addr    = addr;
  assign reg_size    = size;
  assign reg_wdata   = wbuf;
  assign stall       = CAN_STALL ? stall_bit : 1'b0;

endmodule

// File: tb/tb_osd_regaccess_wide.sv
// Scoreboard bench for osd_regaccess_wide: two instances (CAN_STALL=1 / 0), MAX_REG_SIZE=64.
module tb_osd_regaccess_wide;
  import osd_regaccess_pkg::*;

  localparam logic [15:0] ID  = 16'h0042;
  localparam logic [15:0] SRC = 16'h00AB;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          delay;
    bit          no_ack;
    bit          err;
  } reg_exp_t;

  logic        clk, rst, sel, toggle;
  dii_flit     debug_in, in0, in1, out0, out1, cur_out;
  logic        rdy0, rdy1, cur_in_ready, debug_out_ready;
  logic        reg_request, reg_write, reg_ack, reg_err;
  logic        req0, req1, wr0, wr1, stall0, stall1;
  logic [15:0] reg_addr, addr0, addr1;
  logic [1:0]  reg_size, size0, size1;
  logic [63:0] reg_wdata, wdata0, wdata1, reg_rdata;

  logic [16:0] exp_q[$];
  reg_exp_t    reg_q[$];
  logic [15:0] pkt[$];
  int n_cmp = 0, n_bad = 0;
  int rsp_seen = 0, rsp_pushed = 0, req_seen = 0, req_pushed = 0;

  assign in0          = sel ? '0 : debug_in;
  assign in1          = sel ? debug_in : '0;
  assign cur_out      = sel ? out1 : out0;
  assign cur_in_ready = sel ? rdy1 : rdy0;
  assign reg_request  = req0 | req1;
  assign reg_write    = sel ? wr1 : wr0;
  assign reg_addr     = sel ? addr1 : addr0;
  assign reg_size     = sel ? size1 : size0;
  assign reg_wdata    = sel ? wdata1 : wdata0;

  osd_regaccess_wide #(
    .MOD_VENDOR(16'h0001), .MOD_TYPE(16'h0002), .MOD_VERSION(16'h0003),
    .MOD_EVENT_DEST(16'h0010), .CAN_STALL(1'b1), .MAX_REG_SIZE(64), .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clk(clk), .rst(rst), .id(ID), .debug_in(in0), .debug_in_ready(rdy0),
    .debug_out(out0), .debug_out_ready(debug_out_ready), .reg_request(req0),
    .reg_write(wr0), .reg_addr(addr0), .reg_size(size0), .reg_wdata(wdata0),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata), .stall(stall0)
  );

  osd_regaccess_wide #(
    .MOD_VENDOR(16'h0001), .MOD_TYPE(16'h0002), .MOD_VERSION(16'h0003),
    .MOD_EVENT_DEST(16'h0010), .CAN_STALL(1'b0), .MAX_REG_SIZE(64), .TIMEOUT_CYCLES(8)
  ) u_dut_ns (
    .clk(clk), .rst(rst), .id(ID), .debug_in(in1), .debug_in_ready(rdy1),
    .debug_out(out1), .debug_out_ready(debug_out_ready), .reg_request(req1),
    .reg_write(wr1), .reg_addr(addr1), .reg_size(size1), .reg_wdata(wdata1),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata), .stall(stall1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_flit(input logic last, input logic [15:0] d);
    exp_q.push_back({last, d});
    rsp_pushed++;
  endtask

  task automatic exp_head(input logic [15:0] hdr, input logic last);
    exp_flit(1'b0, SRC);
    exp_flit(1'b0, ID);
    exp_flit(last, hdr);
  endtask

  task automatic exp_reg(input logic wr, input logic [15:0] a, input logic [1:0] sz,
                         input logic [63:0] wd, input logic [63:0] rd, input int dly,
                         input bit no_ack, input bit err);
    reg_exp_t e;
    e.wr = wr; e.addr = a; e.size = sz; e.wdata = wd; e.rdata = rd;
    e.delay = dly; e.no_ack = no_ack; e.err = err;
    reg_q.push_back(e);
    req_pushed++;
  endtask

  task automatic tx(input logic [15:0] d, input logic last);
    int n = 0;
    debug_in = {1'b1, last, d};
    while (!cur_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("tx_ready", 64'(cur_in_ready), 64'd1);
    @(negedge clk);
    debug_in = '0;
  endtask

  task automatic send(input bit with_last);
    for (int i = 0; i < pkt.size(); i++) tx(pkt[i], with_last && (i == pkt.size() - 1));
    pkt.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || reg_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain", 64'(exp_q.size() + reg_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Response monitor: owns debug_out_ready; pops the scoreboard on each accepted flit.
  initial begin : monitor
    logic [16:0] e, held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    debug_out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stalled) check("rsp_hold", 64'({cur_out.valid, cur_out.last, cur_out.data}), 64'({1'b1, held}));
      debug_out_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = cur_out.valid && !debug_out_ready;
      held = {cur_out.last, cur_out.data};
      if (cur_out.valid && debug_out_ready) begin
        rsp_seen++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_flit", 64'({cur_out.last, cur_out.data}), 64'(e));
        end
      end
    end
  end

  // Host register model: checks each forwarded access and answers it.
  initial begin : responder
    reg_exp_t e;
    int n;
    reg_ack = 1'b0;
    reg_err = 1'b0;
    reg_rdata = '0;
    forever begin
      @(negedge clk);
      if (reg_request) begin
        req_seen++;
        if (reg_q.size() == 0) begin
          reg_ack = 1'b1;
          @(negedge clk);
          reg_ack = 1'b0;
        end else begin
          e = reg_q.pop_front();
          check("reg_write", 64'(reg_write), 64'(e.wr));
          check("reg_addr", 64'(reg_addr), 64'(e.addr));
          check("reg_size", 64'(reg_size), 64'(e.size));
          if (e.wr) check("reg_wdata", reg_wdata, e.wdata);
          if (e.no_ack) begin
            n = 1;
            while (reg_request && n < 100) begin
              @(negedge clk);
              if (reg_request) n++;
            end
            check("tmo_cycles", 64'(n), 64'd8);
            reg_ack = 1'b1;
            @(negedge clk);
            reg_ack = 1'b0;
          end else begin
            repeat (e.delay) @(negedge clk);
            check("reg_stable", 64'({reg_request, reg_write, reg_size, reg_addr}),
                  64'({1'b1, e.wr, e.size, e.addr}));
            reg_rdata = e.rdata;
            reg_ack = 1'b1;
            reg_err = e.err;
            @(negedge clk);
            reg_ack = 1'b0;
            reg_err = 1'b0;
            reg_rdata = '0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sel = 1'b0; toggle = 1'b0; debug_in = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(cur_in_ready), 64'd0);
    check("rst_out_valid", 64'(cur_out.valid), 64'd0);
    check("rst_reg_request", 64'(reg_request), 64'd0);
    check("rst_stall", 64'(stall0), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(cur_in_ready), 64'd1);

    // Local reads: vendor, event dest, MOD_CS
    exp_head(16'h2000, 1'b0); exp_flit(1'b1, 16'h0001);
    pkt = '{ID, SRC, 16'h0000, 16'h0000}; send(1'b1);
    exp_head(16'h2000, 1'b0); exp_flit(1'b1, 16'h0010);
    pkt = '{ID, SRC, 16'h0000, 16'h0004}; send(1'b1);
    exp_head(16'h2000, 1'b0); exp_flit(1'b1, 16'h0801);
    pkt = '{ID, SRC, 16'h0000, 16'h0003}; send(1'b1);
    drain();

    // External 32-bit write, ack 3 cycles late
    exp_reg(1'b1, 16'h0200, 2'd1, 64'h1234_5678, 64'd0, 3, 1'b0, 1'b0);
    exp_head(16'h3800, 1'b1);
    pkt = '{ID, SRC, 16'h1400, 16'h0200, 16'h1234, 16'h5678}; send(1'b1);
    drain();

    // External 64-bit read, ack with request, backpressured response
    toggle = 1'b1;
    exp_reg(1'b0, 16'h0300, 2'd2, 64'd0, 64'h0011_2233_4455_6677, 0, 1'b0, 1'b0);
    exp_head(16'h2800, 1'b0);
    exp_flit(1'b0, 16'h0011); exp_flit(1'b0, 16'h2233);
    exp_flit(1'b0, 16'h4455); exp_flit(1'b1, 16'h6677);
    pkt = '{ID, SRC, 16'h0800, 16'h0300}; send(1'b1);
    drain();
    toggle = 1'b0;

    // External 16-bit write answered with ack and err together
    exp_reg(1'b1, 16'h0210, 2'd0, 64'h0000_BEEF, 64'd0, 1, 1'b0, 1'b1);
    exp_head(16'h3C00, 1'b1);
    pkt = '{ID, SRC, 16'h1000, 16'h0210, 16'hBEEF}; send(1'b1);
    drain();

    // MOD_CS write clears stall
    exp_head(16'h3800, 1'b1);
    pkt = '{ID, SRC, 16'h1000, 16'h0003, 16'h0800}; send(1'b1);
    drain();
    check("stall_cleared", 64'(stall0), 64'd0);
    exp_head(16'h2000, 1'b0); exp_flit(1'b1, 16'h0800);
    pkt = '{ID, SRC, 16'h0000, 16'h0003}; send(1'b1);
    drain();

    // Error cases; none of these may reach reg_*
    exp_head(16'h3000, 1'b1);                                   // 128-bit read > MAX_REG_SIZE
    pkt = '{ID, SRC, 16'h0C00, 16'h0300}; send(1'b1);
    exp_head(16'h3C00, 1'b1);                                   // last on word 1 of 2
    pkt = '{ID, SRC, 16'h1400, 16'h0200, 16'h1234}; send(1'b1);
    exp_head(16'h3C00, 1'b1);                                   // extra write word
    pkt = '{ID, SRC, 16'h1000, 16'h0200, 16'hAAAA, 16'hBBBB}; send(1'b1);
    exp_head(16'h3000, 1'b1);                                   // read with extra word
    pkt = '{ID, SRC, 16'h0000, 16'h0300, 16'hCCCC}; send(1'b1);
    exp_head(16'h3000, 1'b1);                                   // local read, bad address
    pkt = '{ID, SRC, 16'h0000, 16'h0005}; send(1'b1);
    exp_head(16'h3000, 1'b1);                                   // local read, 32-bit
    pkt = '{ID, SRC, 16'h0400, 16'h0001}; send(1'b1);
    pkt = '{ID, SRC, 16'h4000, 16'h0200}; send(1'b1);           // non-REG type: silent
    drain();

`ifdef OSD_REGACCESS_TIMEOUT_EN
    exp_reg(1'b0, 16'h0400, 2'd0, 64'd0, 64'd0, 0, 1'b1, 1'b0);
    exp_head(16'h3000, 1'b1);
    pkt = '{ID, SRC, 16'h0000, 16'h0400}; send(1'b1);
    drain();
`endif

    // Reset mid-packet: no response, stall returns to its reset value
    pkt = '{ID, SRC, 16'h0000}; send(1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(cur_out.valid), 64'd0);
    check("mid_rst_reg_request", 64'(reg_request), 64'd0);
    check("mid_rst_stall", 64'(stall0), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    exp_head(16'h2000, 1'b0); exp_flit(1'b1, 16'h0801);
    pkt = '{ID, SRC, 16'h0000, 16'h0003}; send(1'b1);
    drain();

    // CAN_STALL=0 instance rejects the MOD_CS write
    sel = 1'b1;
    @(negedge clk);
    exp_head(16'h3C00, 1'b1);
    pkt = '{ID, SRC, 16'h1000, 16'h0003, 16'h0800}; send(1'b1);
    drain();
    check("nostall_stall", 64'(stall1), 64'd0);

    check("rsp_total", 64'(rsp_seen), 64'(rsp_pushed));
    check("req_total", 64'(req_seen), 64'(req_pushed));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
